// File: rtl/probe_scanner_pkg.sv
// probe_scanner shared types and constants
// display tag width, invalid marker, FSM encoding
package probe_scanner_pkg;

  localparam int PROBE_TAG_W = 4;
  localparam logic [31:0] PROBE_INVALID = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    FROZEN = 2'd2
  } scanState_t;

endpackage

// File: rtl/probe_scanner_if.sv
// probe_scanner interface: probe inputs, controls, display word
// master drives probes/controls, slave is the scanner
interface probe_scanner_if #(
  parameter int N_PROBES = 8,
  parameter int XLEN     = 32,
  parameter int IDX_W    = 3
);

  logic                     en;
  logic                     freeze;
  logic                     step_btn;
  logic [IDX_W-1:0]         idx_lo;
  logic [IDX_W-1:0]         idx_hi;
  logic [N_PROBES*XLEN-1:0] probe_bus;
  logic [N_PROBES-1:0]      probe_valid;
  logic [XLEN-1:0]          disp_data;
  logic [IDX_W-1:0]         disp_idx;
  logic                     disp_valid;
  logic                     frozen;

  modport master (
    output en, freeze, step_btn,
    output idx_lo, idx_hi,
    output probe_bus, probe_valid,
    input  disp_data, disp_idx,
    input  disp_valid, frozen
  );

  modport slave (
    input  en, freeze, step_btn,
    input  idx_lo, idx_hi,
    input  probe_bus, probe_valid,
    output disp_data, disp_idx,
    output disp_valid, frozen
  );

endinterface

// File: rtl/probe_scanner_next_idx.sv
// probe_next_idx: wrap-around search for the next valid
// probe inside the scan window; also reports window start
module probe_next_idx
  import probe_scanner_pkg::*;
#(
  parameter int N_PROBES = 8,
  parameter int IDX_W    = 3
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic [IDX_W-1:0]    idxLo,
  input  logic [IDX_W-1:0]    idxHi,
  input  logic [N_PROBES-1:0] mask,
  output logic [IDX_W-1:0]    nextIdx,
  output logic [IDX_W-1:0]    winStart,
  output logic                inWin
);

  logic             full;
  logic             found;
  logic [IDX_W-1:0] winEnd;
  logic [IDX_W-1:0] cand;
  int               span;
  int               pos;
  int               c;

  // window bounds, then scan offsets 1..span-1 from idx
  always_comb begin
    full     = idxLo > idxHi;
    winStart = full ? '0 : idxLo;
    winEnd   = full ? IDX_W'(N_PROBES - 1) : idxHi;
    inWin    = (idx >= winStart) && (idx <= winEnd);
    span     = int'(winEnd) - int'(winStart) + 1;
    pos      = int'(idx) - int'(winStart);
    nextIdx  = idx;
    found    = 1'b0;
    c        = 0;
    cand     = '0;
    for (int k = 1; k < N_PROBES; k++) begin
      c = pos + k;
      if (c >= span)
        c = c - span;
      cand = IDX_W'(int'(winStart) + c);
      if (!found && (k < span) && mask[cand]) begin
        found   = 1'b1;
        nextIdx = cand;
      end
    end
  end

endmodule

// File: rtl/probe_scanner.sv
// probe_scanner: debug display sequencer for seg7x16
// auto dwell scan, hold, freeze snapshot with single step
module probe_scanner
  import probe_scanner_pkg::*;
#(
  parameter int N_PROBES = 8,
  parameter int XLEN     = 32,
  parameter int DWELL    = 4,
  parameter int IDX_W    = 3
) (
  input  logic            CLK_TEST,
  input  logic            rstn,
  probe_scanner_if.slave  bus
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  scanState_t              state;
  scanState_t              stateNx;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idxNx;
  logic [DW_W-1:0]         dwellCnt;
  logic [DW_W-1:0]         dwellNx;
  logic                    freezeQ;
  logic                    stepQ;
  logic [XLEN-1:0]         snapData [N_PROBES];
  logic [N_PROBES-1:0]     snapValid;

  logic                    freezeRise;
  logic                    freezeFall;
  logic                    stepRise;
  logic [N_PROBES-1:0]     searchMask;
  logic [IDX_W-1:0]        nextIdx;
  logic [IDX_W-1:0]        winStart;
  logic                    inWin;
  logic [XLEN-1:0]         liveWord;
  logic [XLEN-1:0]         selWord;
  logic                    selValid;
  logic [PROBE_TAG_W-1:0]  tag;

  assign freezeRise = bus.freeze & ~freezeQ;
  assign freezeFall = ~bus.freeze & freezeQ;
  assign stepRise   = bus.step_btn & ~stepQ;

  // frozen browsing walks the captured mask
  assign searchMask = (state == FROZEN) ?
                      snapValid : bus.probe_valid;

  probe_next_idx #(
    .N_PROBES (N_PROBES),
    .IDX_W    (IDX_W)
  ) u_next (
    .idx      (idx),
    .idxLo    (bus.idx_lo),
    .idxHi    (bus.idx_hi),
    .mask     (searchMask),
    .nextIdx  (nextIdx),
    .winStart (winStart),
    .inWin    (inWin)
  );

  assign liveWord = bus.probe_bus[int'(idx)*XLEN +: XLEN];
  assign selWord  = (state == FROZEN) ? snapData[idx] : liveWord;
  assign selValid = (state == FROZEN) ?
                    snapValid[idx] : bus.probe_valid[idx];
  assign tag = PROBE_TAG_W'(idx) + PROBE_TAG_W'(1);

  // edge detectors for freeze level and step button
  always_ff @(posedge CLK_TEST or negedge rstn) begin
    if (!rstn) begin
      freezeQ <= 1'b0;
      stepQ   <= 1'b0;
    end else begin
      freezeQ <= bus.freeze;
      stepQ   <= bus.step_btn;
    end
  end

  // capture every probe and the mask on entry to FROZEN
  always_ff @(posedge CLK_TEST or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_PROBES; i++)
        snapData[i] <= '0;
      snapValid <= '0;
    end else if (freezeRise && state != FROZEN) begin
      for (int i = 0; i < N_PROBES; i++)
        snapData[i] <= bus.probe_bus[i*XLEN +: XLEN];
      snapValid <= bus.probe_valid;
    end
  end

  // state, index and dwell registers
  always_ff @(posedge CLK_TEST or negedge rstn) begin
    if (!rstn) begin
      state    <= RUN;
      idx      <= '0;
      dwellCnt <= '0;
    end else begin
      state    <= stateNx;
      idx      <= idxNx;
      dwellCnt <= dwellNx;
    end
  end

  // next state; out-of-window snap overrides any advance
  always_comb begin
    stateNx = state;
    idxNx   = idx;
    dwellNx = dwellCnt;
    unique case (state)
      RUN: begin
        if (freezeRise)
          stateNx = FROZEN;
        else if (!bus.en)
          stateNx = HOLD;
        else if (dwellCnt == DW_LAST) begin
          idxNx   = nextIdx;
          dwellNx = '0;
        end else
          dwellNx = dwellCnt + 1'b1;
      end
      HOLD: begin
        if (freezeRise)
          stateNx = FROZEN;
        else if (bus.en) begin
          stateNx = RUN;
          dwellNx = '0;
        end
      end
      FROZEN: begin
        if (freezeFall) begin
          stateNx = RUN;
          dwellNx = '0;
        end else if (stepRise)
          idxNx = nextIdx;
      end
      default: stateNx = RUN;
    endcase
    if (!inWin) begin
      idxNx   = winStart;
      dwellNx = '0;
    end
  end

  // registered display word, one cycle behind idx
  always_ff @(posedge CLK_TEST or negedge rstn) begin
    if (!rstn) begin
      bus.disp_data  <= '0;
      bus.disp_idx   <= '0;
      bus.disp_valid <= 1'b0;
      bus.frozen     <= 1'b0;
    end else begin
      bus.disp_data  <= selValid ?
        {tag, selWord[XLEN-PROBE_TAG_W-1:0]} :
        XLEN'(PROBE_INVALID);
      bus.disp_idx   <= idx;
      bus.disp_valid <= selValid;
      bus.frozen     <= (state == FROZEN);
    end
  end

endmodule

// File: tb/tb_probe_scanner.sv
// tb_probe_scanner: per-cycle scoreboard against a behavioural
// model plus a table of hand-traced checkpoints
module tb_probe_scanner;

  localparam int N  = 8;
  localparam int XL = 32;
  localparam int IW = 3;
  localparam int DW = 4;

  logic CLK_TEST = 1'b0;
  logic rstn     = 1'b1;

  probe_scanner_if #(.N_PROBES(N), .XLEN(XL), .IDX_W(IW)) pif ();

  probe_scanner #(
    .N_PROBES (N),
    .XLEN     (XL),
    .DWELL    (DW),
    .IDX_W    (IW)
  ) dut (
    .CLK_TEST (CLK_TEST),
    .rstn     (rstn),
    .bus      (pif.slave)
  );

  always #5 CLK_TEST = ~CLK_TEST;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
    logic        valid;
    logic        frz;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic        en, frz, stp, zero;
    logic [2:0]  lo, hi;
    logic [7:0]  msk;
    int          n;
    logic [2:0]  eIdx;
    logic [31:0] eData;
    logic        eVal, eFrz;
  } row_t;

  row_t tbl[34];

  logic [31:0] mSnap[N];
  logic [7:0]  mSnapV;
  int          mSt, mIdx, mDw;
  logic        mFq, mSq;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setLive(input logic z);
    for (int i = 0; i < N; i++)
      pif.probe_bus[i*32 +: 32] = z ? 32'h0 : 32'h0A00_0000 + i;
  endtask

  function automatic int nextOf(input int cur, input logic [7:0] m,
                                input int ws, input int we);
    int i;
    int res;
    logic hit;
    i = cur;
    res = cur;
    hit = 1'b0;
    for (int k = 0; k < we - ws; k++) begin
      i = (i == we) ? ws : i + 1;
      if (!hit && m[i]) begin
        hit = 1'b1;
        res = i;
      end
    end
    return res;
  endfunction

  task automatic mReset();
    mSt = 0; mIdx = 0; mDw = 0;
    mFq = 1'b0; mSq = 1'b0; mSnapV = '0;
    for (int i = 0; i < N; i++) mSnap[i] = '0;
  endtask

  task automatic mStep();
    exp_t e;
    int ws, we, nx, old;
    logic [31:0] w;
    logic v, fr, ff, sr;
    logic [7:0] m;
    ws = (pif.idx_lo > pif.idx_hi) ? 0 : int'(pif.idx_lo);
    we = (pif.idx_lo > pif.idx_hi) ? N - 1 : int'(pif.idx_hi);
    if (mSt == 2) begin
      w = mSnap[mIdx]; v = mSnapV[mIdx];
    end else begin
      w = pif.probe_bus[mIdx*32 +: 32]; v = pif.probe_valid[mIdx];
    end
    e.idx = 3'(mIdx);
    e.valid = v;
    e.frz = (mSt == 2);
    e.data = v ? {4'(mIdx + 1), w[27:0]} : 32'hFFFF_FFFF;
    sbq.push_back(e);
    fr = pif.freeze && !mFq;
    ff = !pif.freeze && mFq;
    sr = pif.step_btn && !mSq;
    m = (mSt == 2) ? mSnapV : pif.probe_valid;
    nx = nextOf(mIdx, m, ws, we);
    old = mIdx;
    if (mSt != 2 && fr) begin
      for (int i = 0; i < N; i++) mSnap[i] = pif.probe_bus[i*32 +: 32];
      mSnapV = pif.probe_valid;
      mSt = 2;
    end else if (mSt == 0) begin
      if (!pif.en) mSt = 1;
      else if (mDw == DW - 1) begin mIdx = nx; mDw = 0; end
      else mDw++;
    end else if (mSt == 1) begin
      if (pif.en) begin mSt = 0; mDw = 0; end
    end else begin
      if (ff) begin mSt = 0; mDw = 0; end
      else if (sr) mIdx = nx;
    end
    if (old < ws || old > we) begin
      mIdx = ws; mDw = 0;
    end
    mFq = pif.freeze;
    mSq = pif.step_btn;
  endtask

  task automatic cyc();
    exp_t e;
    mStep();
    @(negedge CLK_TEST);
    e = sbq.pop_front();
    check("sb_idx", 32'(pif.disp_idx), 32'(e.idx));
    check("sb_data", pif.disp_data, e.data);
    check("sb_valid", 32'(pif.disp_valid), 32'(e.valid));
    check("sb_frozen", 32'(pif.frozen), 32'(e.frz));
  endtask

  task automatic checkZero(input string nm);
    check({nm, "_data"}, pif.disp_data, 32'h0);
    check({nm, "_idx"}, 32'(pif.disp_idx), 32'h0);
    check({nm, "_valid"}, 32'(pif.disp_valid), 32'h0);
    check({nm, "_frozen"}, 32'(pif.frozen), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    //        en fz st zr lo hi msk    n  idx data          v  f
    tbl[0]  = '{1,0,0,0,0,7,8'hFF, 1, 0,32'h1A00_0000,1,0};
    tbl[1]  = '{1,0,0,0,0,7,8'hFF,13, 3,32'h4A00_0003,1,0};
    tbl[2]  = '{1,1,0,0,0,7,8'hFF, 1, 3,32'h4A00_0003,1,0};
    tbl[3]  = '{1,1,0,1,0,7,8'hFF, 2, 3,32'h4A00_0003,1,1};
    tbl[4]  = '{1,1,1,1,0,7,8'hFF, 1, 3,32'h4A00_0003,1,1};
    tbl[5]  = '{1,1,0,1,0,7,8'hFF, 1, 4,32'h5A00_0004,1,1};
    tbl[6]  = '{1,1,1,1,0,7,8'hFF, 1, 4,32'h5A00_0004,1,1};
    tbl[7]  = '{1,1,0,1,0,7,8'hFF, 2, 5,32'h6A00_0005,1,1};
    tbl[8]  = '{1,0,1,1,0,7,8'hFF, 1, 5,32'h6A00_0005,1,1};
    tbl[9]  = '{1,0,1,1,0,7,8'hFF, 1, 5,32'h6000_0000,1,0};
    tbl[10] = '{0,0,0,0,0,7,8'hFF,10, 5,32'h6A00_0005,1,0};
    tbl[11] = '{1,0,0,0,0,7,8'hFF, 5, 5,32'h6A00_0005,1,0};
    tbl[12] = '{1,0,0,0,0,7,8'hFF, 1, 6,32'h7A00_0006,1,0};
    tbl[13] = '{1,1,1,0,0,7,8'hFF, 1, 6,32'h7A00_0006,1,0};
    tbl[14] = '{1,1,1,0,0,7,8'hFF, 2, 6,32'h7A00_0006,1,1};
    tbl[15] = '{1,1,0,0,0,7,8'hFF, 1, 6,32'h7A00_0006,1,1};
    tbl[16] = '{1,1,1,0,0,7,8'hFF, 1, 6,32'h7A00_0006,1,1};
    tbl[17] = '{1,1,0,0,0,7,8'hFF, 1, 7,32'h8A00_0007,1,1};
    tbl[18] = '{1,1,1,0,0,7,8'hFF, 1, 7,32'h8A00_0007,1,1};
    tbl[19] = '{1,1,0,0,0,7,8'hFF, 1, 0,32'h1A00_0000,1,1};
    tbl[20] = '{0,0,0,0,0,7,8'hFF, 1, 0,32'h1A00_0000,1,1};
    tbl[21] = '{0,0,0,0,0,7,8'hFF, 3, 0,32'h1A00_0000,1,0};
    tbl[22] = '{1,0,0,0,0,7,8'hFF, 6, 1,32'h2A00_0001,1,0};
    tbl[23] = '{1,0,0,0,0,7,8'hA5, 1, 1,32'hFFFF_FFFF,0,0};
    tbl[24] = '{1,0,0,0,0,7,8'hA5, 3, 2,32'h3A00_0002,1,0};
    tbl[25] = '{1,0,0,0,0,7,8'hA5,12, 0,32'h1A00_0000,1,0};
    tbl[26] = '{1,0,0,0,0,7,8'h08, 8, 3,32'h4A00_0003,1,0};
    tbl[27] = '{1,0,0,0,0,7,8'h00, 8, 3,32'hFFFF_FFFF,0,0};
    tbl[28] = '{1,0,0,0,5,2,8'hFF, 4, 4,32'h5A00_0004,1,0};
    tbl[29] = '{1,0,0,0,6,7,8'hFF, 1, 4,32'h5A00_0004,1,0};
    tbl[30] = '{1,0,0,0,6,7,8'hFF, 1, 6,32'h7A00_0006,1,0};
    tbl[31] = '{1,0,0,0,6,7,8'hFF, 3, 6,32'h7A00_0006,1,0};
    tbl[32] = '{1,0,0,0,6,7,8'hFF, 1, 7,32'h8A00_0007,1,0};
    tbl[33] = '{1,0,0,0,6,7,8'hFF, 4, 6,32'h7A00_0006,1,0};

    pif.en = 1'b1;
    pif.freeze = 1'b0;
    pif.step_btn = 1'b0;
    pif.idx_lo = 3'd0;
    pif.idx_hi = 3'd7;
    pif.probe_valid = 8'hFF;
    setLive(1'b0);
    mReset();

    #1 rstn = 1'b0;
    #1 checkZero("reset");
    @(negedge CLK_TEST);
    @(negedge CLK_TEST);
    rstn = 1'b1;

    repeat (10) cyc();
    pif.freeze = 1'b1;
    cyc();
    setLive(1'b1);
    repeat (2) cyc();
    check("freeze_idx", 32'(pif.disp_idx), 32'd2);
    check("freeze_data", pif.disp_data, 32'h3A00_0002);
    for (int k = 0; k < 16 && pif.disp_idx != 3'd5; k++) begin
      pif.step_btn = 1'b1;
      cyc();
      pif.step_btn = 1'b0;
      cyc();
    end
    check("step_to5_idx", 32'(pif.disp_idx), 32'd5);
    check("step_to5_data", pif.disp_data, 32'h6A00_0005);
    check("step_to5_frozen", 32'(pif.frozen), 32'd1);

    #2 rstn = 1'b0;
    #1 checkZero("async_rst");
    pif.freeze = 1'b0;
    pif.step_btn = 1'b0;
    sbq.delete();
    mReset();
    @(negedge CLK_TEST);
    rstn = 1'b1;

    for (int r = 0; r < 34; r++) begin
      pif.en = tbl[r].en;
      pif.freeze = tbl[r].frz;
      pif.step_btn = tbl[r].stp;
      pif.idx_lo = tbl[r].lo;
      pif.idx_hi = tbl[r].hi;
      pif.probe_valid = tbl[r].msk;
      setLive(tbl[r].zero);
      repeat (tbl[r].n) cyc();
      check($sformatf("row%0d_idx", r),
            32'(pif.disp_idx), 32'(tbl[r].eIdx));
      check($sformatf("row%0d_data", r), pif.disp_data, tbl[r].eData);
      check($sformatf("row%0d_valid", r),
            32'(pif.disp_valid), 32'(tbl[r].eVal));
      check($sformatf("row%0d_frozen", r),
            32'(pif.frozen), 32'(tbl[r].eFrz));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
